// File: rtl/reg_wb_queue_pkg.sv
// rtl/reg_wb_queue_pkg.sv - shared defaults and queue entry type for the register writeback queue
package wb_pkg;

  localparam int WB_DW    = 32;
  localparam int WB_AW    = 5;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  // Count must reach DEPTH itself, hence one bit above the pointer width.
  function automatic int wb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_wb_queue_if.sv
// rtl/reg_wb_queue_if.sv - writeback sources, register-file write port and hazard check bundle
interface reg_wb_queue_if
  import wb_pkg::*;
#(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW
);

  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic [AW-1:0] pend_addr1;
  logic [AW-1:0] pend_addr2;
  logic          pend_hit1;
  logic          pend_hit2;
  logic [DW-1:0] byp_data1;
  logic [DW-1:0] byp_data2;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, pend_addr1, pend_addr2,
    input  a_ready, b_ready, we, waddr, wdata, busy, pend_hit1, pend_hit2, byp_data1, byp_data2
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, pend_addr1, pend_addr2,
    output a_ready, b_ready, we, waddr, wdata, busy, pend_hit1, pend_hit2, byp_data1, byp_data2
  );

endinterface

// File: rtl/reg_wb_queue_fifo.sv
// rtl/reg_wb_queue_fifo.sv - two-push one-pop entry storage with wrapping pointers
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = WB_DEPTH,
  parameter type entry_t = wb_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = wb_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_a,
  input  entry_t        ent_a,
  input  logic          push_b,
  input  entry_t        ent_b,
  input  logic          pop,
  output entry_t        head,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output entry_t        mem [DEPTH]
);

  logic [PW-1:0] wr_ptr;
  logic [1:0]    n_push;
  logic          pop_ok;

  assign n_push = {1'b0, push_a} + {1'b0, push_b};
  assign pop_ok = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(pop_ok);
      count  <= count + CW'(n_push) - CW'(pop_ok);
    end
  end

  // B lands behind A when both push, otherwise takes A's slot.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr] <= ent_a;
    if (push_b) mem[push_a ? wr_ptr + PW'(1) : wr_ptr] <= ent_b;
  end

endmodule

// File: rtl/reg_wb_queue.sv
// rtl/reg_wb_queue.sv - register-file writeback queue: A/B arbitration, zero drop, hazard hit/bypass
// Optional forwarding of youngest pending data enabled by macro WB_BYPASS_EN.
module reg_wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW
) (
  input logic           clk,
  input logic           rst,
  reg_wb_queue_if.slave wb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = wb_cnt_w(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        ent_a, ent_b, head;
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count, free;
  logic          push_a, push_b, pop;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic          hit1, hit2;

  // Readiness looks only at registered occupancy, never at the pop in flight.
  assign free       = CW'(DEPTH) - count;
  assign wb.a_ready = rst && (free >= CW'(1));
  assign wb.b_ready = rst && (wb.a_valid ? (free >= CW'(2)) : (free >= CW'(1)));

  assign ent_a  = '{addr: wb.a_addr, data: wb.a_data};
  assign ent_b  = '{addr: wb.b_addr, data: wb.b_data};
  assign push_a = wb.a_valid && wb.a_ready && (wb.a_addr != '0);
  assign push_b = wb.b_valid && wb.b_ready && (wb.b_addr != '0);
  assign pop    = (count != '0);

  wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_a (push_a),
    .ent_a  (ent_a),
    .push_b (push_b),
    .ent_b  (ent_b),
    .pop    (pop),
    .head   (head),
    .rd_ptr (rd_ptr),
    .count  (count),
    .mem    (mem_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        waddr_q <= head.addr;
        wdata_q <= head.data;
      end
    end
  end

  assign wb.we    = we_q;
  assign wb.waddr = waddr_q;
  assign wb.wdata = wdata_q;
  assign wb.busy  = (count != '0) || we_q;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    if (we_q && waddr_q == wb.pend_addr1) hit1 = 1'b1;
    if (we_q && waddr_q == wb.pend_addr2) hit2 = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if (mem_q[rd_ptr + PW'(k)].addr == wb.pend_addr1) hit1 = 1'b1;
        if (mem_q[rd_ptr + PW'(k)].addr == wb.pend_addr2) hit2 = 1'b1;
      end
    end
    if (wb.pend_addr1 == '0) hit1 = 1'b0;
    if (wb.pend_addr2 == '0) hit2 = 1'b0;
  end

  assign wb.pend_hit1 = hit1;
  assign wb.pend_hit2 = hit2;

`ifdef WB_BYPASS_EN
  logic [DW-1:0] byp1, byp2;

  // Walk oldest to youngest so the last match (tail side) wins.
  always_comb begin
    byp1 = '0;
    byp2 = '0;
    if (we_q && waddr_q == wb.pend_addr1) byp1 = wdata_q;
    if (we_q && waddr_q == wb.pend_addr2) byp2 = wdata_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if (mem_q[rd_ptr + PW'(k)].addr == wb.pend_addr1) byp1 = mem_q[rd_ptr + PW'(k)].data;
        if (mem_q[rd_ptr + PW'(k)].addr == wb.pend_addr2) byp2 = mem_q[rd_ptr + PW'(k)].data;
      end
    end
  end

  assign wb.byp_data1 = hit1 ? byp1 : '0;
  assign wb.byp_data2 = hit2 ? byp2 : '0;
`else
  assign wb.byp_data1 = '0;
  assign wb.byp_data2 = '0;
`endif

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries; power of two, 2..16.
REQ-002 Parameter DW, default 32, meaning write-data width.
REQ-003 Parameter AW, default 5, meaning register address width.
REQ-004 Reset is rst, asynchronous, active-low; clock is clk.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 a_valid/a_ready  in/out  1/1  ALU writeback handshake, priority source.
REQ-008 a_addr/a_data  in  AW/DW  ALU destination register and result.
REQ-009 b_valid/b_ready  in/out  1/1  load/multi-cycle writeback handshake.
REQ-010 b_addr/b_data  in  AW/DW  source B destination and result.
REQ-011 we  out  1  register-file write enable (drives WE3).
REQ-012 waddr/wdata  out  AW/DW  register-file write address/data (drive A3/WD3).
REQ-013 busy  out  1  high when queue non-empty or we high.
REQ-014 pend_addr1/pend_addr2  in  AW  decode-stage source registers under check.
REQ-015 pend_hit1/pend_hit2  out  1  matching write still pending.
REQ-016 byp_data1/byp_data2  out  DW  youngest pending data for the match (macro-gated).

Function
REQ-017 A request SHALL be accepted at a rising edge where valid and ready are both high.
REQ-018 free = DEPTH - count; a_ready SHALL be (free >= 1).
REQ-019 b_ready SHALL be (free >= 2) when a_valid high, else (free >= 1); ready never depends on same-cycle pop.
REQ-020 Both accepted in one cycle: A SHALL be enqueued ahead of B.
REQ-021 Accepted requests with addr == 0 SHALL be dropped, not enqueued, consuming no slot; ready rules are unchanged.
REQ-022 Each edge with count > 0 SHALL pop the head into registered we=1/waddr/wdata; with count == 0, we SHALL be 0 and waddr/wdata hold.
REQ-023 Latency: request accepted at edge N into empty queue SHALL appear on we/waddr/wdata after edge N+1; one write per cycle.
REQ-024 Push and pop in the same edge SHALL both occur; count changes by pushes minus pop.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; count range 0..DEPTH, never overflows.
REQ-026 pend_hitK SHALL be high when pend_addrK != 0 and matches any valid queue entry or the output register while we=1.
REQ-027 Writes SHALL retire in acceptance order; same address queued twice is written twice in order.

Reset
REQ-028 rst low SHALL asynchronously clear count, pointers, we, waddr, wdata to 0; queue contents are discarded.
REQ-029 While rst low, a_ready and b_ready SHALL be 0; reset mid-operation loses pending writes without a partial write.

Configuration
REQ-030 Macro WB_BYPASS_EN defined: byp_dataK SHALL give data of the youngest match (queue tail side first, output register last), 0 when pend_hitK low.
REQ-031 Macro undefined: byp_data1/byp_data2 SHALL be constant 0; pend_hit logic remains for stall generation.

Structure
REQ-032 Shared package wb_pkg SHALL hold DW/AW/DEPTH defaults and the entry type {addr, data}.
REQ-033 Storage and pointers SHALL live in one sub-module wb_fifo (two-push, one-pop); arbitration, zero-drop, hit/bypass logic in reg_wb_queue.

Verification
REQ-034 Single write: a_valid, addr 5, data 0xDEADBEEF at edge 1 -> we=1, waddr=5, wdata=0xDEADBEEF after edge 2, we=0 after edge 3.
REQ-035 Dual push: A(3,0x11) and B(4,0x22) same edge -> writes addr 3 then addr 4 on consecutive cycles.
REQ-036 Fill: DEPTH=4, hold sink-side count at 3 with a_valid and b_valid high -> a_ready=1, b_ready=0; only A accepted.
REQ-037 Zero drop: a_valid addr 0 data 0x55 -> accepted, no we pulse, count unchanged.
REQ-038 Hazard: queue holds (7,0xA) then (7,0xB), pend_addr1=7 -> pend_hit1=1, byp_data1=0xB with WB_BYPASS_EN, 0 without.
REQ-039 Reset: assert rst with 3 entries queued -> we=0, busy=0 immediately, no writes after release.
